// File: rtl/dma_copy_engine.sv
// dma_copy_engine
//   Bus initiator for the data-memory port. It copies a block of 32-bit words
//   from a source byte address to a destination byte address, one word per
//   read/write pair. The port is shared with the CPU through a
//   bus_req/bus_grant handshake. Any access that would touch the peripheral
//   region (Address[31:28] == PERIPH_NIB) is refused, and the copy aborts
//   with an error pulse.
//
// Ports
//   clk        in   system clock; all state changes on the rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   one-cycle copy request; sampled only while idle
//   src_addr   in   [31:0] first source byte address ([1:0] ignored)
//   dst_addr   in   [31:0] first destination byte address ([1:0] ignored)
//   length     in   [LEN_W-1:0] number of words to copy
//   bus_grant  in   CPU has released the memory port
//   Read_data  in   [31:0] combinational read data from data memory
//   bus_req    out  memory port request
//   Address    out  [31:0] memory address, word aligned
//   Write_data out  [31:0] memory write data
//   MemRead    out  read strobe
//   MemWrite   out  write strobe
//   busy       out  copy in progress
//   done       out  one-cycle pulse on successful completion
//   error      out  one-cycle pulse on peripheral-region abort
module dma_copy_engine #(
    parameter int         LEN_W      = 8,
    parameter logic [3:0] PERIPH_NIB = 4'b0100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    input  logic             bus_grant,
    input  logic [31:0]      Read_data,
    output logic             bus_req,
    output logic [31:0]      Address,
    output logic [31:0]      Write_data,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]       r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_data;
    logic             r_err;   // selects error rather than done in FIN

    logic             w_periph;

    // Either end of the current word lies in the peripheral region.
    assign w_periph = (r_src[31:28] == PERIPH_NIB) || (r_dst[31:28] == PERIPH_NIB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        if (length != '0) begin
                            r_src   <= src_addr & ~32'h3;
                            r_dst   <= dst_addr & ~32'h3;
                            r_cnt   <= length;
                            r_state <= S_REQ;
                        end else begin
                            // Empty block: report completion without touching the bus.
                            r_state <= S_FIN;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_grant) begin
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (w_periph) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_data  <= Read_data;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_src <= r_src + 32'd4;
                    r_dst <= r_dst + 32'd4;
                    r_cnt <= r_cnt - LEN_W'(1);
                    // The port may only be yielded here, between whole words.
                    if (r_cnt == LEN_W'(1)) begin
                        r_state <= S_FIN;
                    end else if (bus_grant) begin
                        r_state <= S_RD;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs: everything is decoded from registered state only.
    always_comb begin
        bus_req    = 1'b0;
        Address    = '0;
        Write_data = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
            end
            S_RD: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (!w_periph) begin
                    MemRead = 1'b1;
                    Address = r_src;
                end
            end
            S_WR: begin
                bus_req    = 1'b1;
                busy       = 1'b1;
                MemWrite   = 1'b1;
                Address    = r_dst;
                Write_data = r_data;
            end
            S_FIN: begin
                done  = !r_err;
                error = r_err;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine
//   Directed bench for dma_copy_engine. A behavioural word memory answers the
//   engine's strobes; a vector table drives whole copies with the grant held,
//   and hand-written sequences cover grant stalls and reset during a copy.
module tb_dma_copy_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [7:0]  length;
    logic        bus_grant;
    logic [31:0] Read_data;
    logic        bus_req;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] refm [logic [31:0]];
    logic [31:0] rdq[$];
    logic [31:0] wrq[$];

    typedef struct {
        string       name;
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        int          cyc;   // cycles from start edge to done/error
        bit          err;
        int          nwr;   // words actually transferred
    } vec_t;

    vec_t vecs[8];

    dma_copy_engine #(
        .LEN_W(8),
        .PERIPH_NIB(4'b0100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .length(length),
        .bus_grant(bus_grant),
        .Read_data(Read_data),
        .bus_req(bus_req),
        .Address(Address),
        .Write_data(Write_data),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : pat(a);
    endfunction

    function automatic int mem_diff();
        int d = 0;
        if (mem.size() != refm.size()) d++;
        foreach (refm[a]) begin
            if (!mem.exists(a)) d++;
            else if (mem[a] !== refm[a]) d++;
        end
        return d;
    endfunction

    // Memory model and per-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (MemRead) begin
            Read_data = mem.exists(Address) ? mem[Address] : pat(Address);
            rdq.push_back(Address);
        end else begin
            Read_data = '0;
        end
        if (MemWrite) begin
            mem[Address] = Write_data;
            wrq.push_back(Address);
        end
        chk("strobe_exclusive", 64'(MemRead & MemWrite), 64'd0);
        chk("bus_quiet", (!MemRead && !MemWrite) ? {Address, Write_data} : 64'd0, 64'd0);
        chk("addr_aligned", 64'(Address[1:0]), 64'd0);
        chk("req_matches_busy", 64'(bus_req), 64'(busy));
    end

    task automatic clear_model();
        mem.delete();
        refm.delete();
        rdq.delete();
        wrq.delete();
    endtask

    task automatic issue_start(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = 32'hDEAD_BEEF;
        dst_addr = 32'h4BAD_F00D;
        length   = 8'hFF;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] sa;
        logic [31:0] da;
        int          k;
        int          cyc;
        int          busy_bad;
        int          addr_bad;
        logic [1:0]  flags;
        clear_model();
        sa = v.src & ~32'h3;
        da = v.dst & ~32'h3;
        for (int i = 0; i < v.nwr; i++) refm[da + 32'(4 * i)] = ref_rd(sa + 32'(4 * i));
        bus_grant = 1'b1;
        issue_start(v.src, v.dst, v.len);
        k = 0;
        cyc = -1;
        busy_bad = 0;
        flags = 2'b00;
        while (cyc < 0 && k < v.cyc + 20) begin
            @(negedge clk);
            k++;
            if (done || error) begin
                cyc = k;
                flags = {done, error};
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
        end
        chk({v.name, " latency"}, 64'(cyc), 64'(v.cyc));
        chk({v.name, " done_error"}, 64'(flags), v.err ? 64'b01 : 64'b10);
        chk({v.name, " busy_window"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk({v.name, " single_pulse"}, 64'({done, error, busy}), 64'd0);
        chk({v.name, " read_count"}, 64'(rdq.size()), 64'(v.nwr));
        chk({v.name, " write_count"}, 64'(wrq.size()), 64'(v.nwr));
        addr_bad = 0;
        foreach (rdq[i]) if (rdq[i] !== sa + 32'(4 * i)) addr_bad++;
        foreach (wrq[i]) if (wrq[i] !== da + 32'(4 * i)) addr_bad++;
        chk({v.name, " address_order"}, 64'(addr_bad), 64'd0);
        chk({v.name, " contents"}, 64'(mem_diff()), 64'd0);
    endtask

    initial begin
        int k;
        int cyc;
        int stall_bad;
        int idle_bad;
        logic [1:0] flags;

        vecs[0] = '{"basic",     32'h0000_0010, 32'h0000_0080, 8'd4,   10,  1'b0, 4};
        vecs[1] = '{"src_periph", 32'h3FFF_FFF8, 32'h0000_0100, 8'd4,  7,   1'b1, 2};
        vecs[2] = '{"wrap",      32'hFFFF_FFF8, 32'h0000_0200, 8'd4,   10,  1'b0, 4};
        vecs[3] = '{"overlap",   32'h0000_0400, 32'h0000_0404, 8'd3,   8,   1'b0, 3};
        vecs[4] = '{"unaligned", 32'h0000_0503, 32'h0000_0602, 8'd1,   4,   1'b0, 1};
        vecs[5] = '{"dst_periph", 32'h0000_1000, 32'h4000_0000, 8'd2,  3,   1'b1, 0};
        vecs[6] = '{"zero_len",  32'h0000_0010, 32'h0000_0080, 8'd0,   1,   1'b0, 0};
        vecs[7] = '{"max_len",   32'h0000_2000, 32'h0000_3000, 8'd255, 512, 1'b0, 255};

        reset     = 1'b0;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        bus_grant = 1'b1;
        Read_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", 64'({bus_req, MemRead, MemWrite, busy, done, error}), 64'd0);
        chk("reset_address", 64'(Address), 64'd0);
        chk("reset_wdata", 64'(Write_data), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Grant withheld for the first five request cycles, then again for
        // three cycles after the second word is written.
        clear_model();
        for (int i = 0; i < 4; i++) refm[32'h80 + 32'(4 * i)] = pat(32'h10 + 32'(4 * i));
        bus_grant = 1'b0;
        issue_start(32'h10, 32'h80, 8'd4);
        k = 0;
        cyc = -1;
        stall_bad = 0;
        flags = 2'b00;
        while (cyc < 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (done || error) begin
                cyc = k;
                flags = {done, error};
            end
            if ((k <= 6 || (k >= 11 && k <= 13)) && (!bus_req || MemRead || MemWrite)) stall_bad++;
            bus_grant = !((k <= 5) || (k >= 10 && k <= 12));
        end
        bus_grant = 1'b1;
        chk("stall latency", 64'(cyc), 64'd18);
        chk("stall done", 64'(flags), 64'b10);
        chk("stall waiting", 64'(stall_bad), 64'd0);
        chk("stall contents", 64'(mem_diff()), 64'd0);

        // Reset asserted during the write of the third word of an 8-word copy.
        clear_model();
        refm[32'h80] = pat(32'h10);
        refm[32'h84] = pat(32'h14);
        issue_start(32'h10, 32'h80, 8'd8);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_flags", 64'({bus_req, MemRead, MemWrite, busy, done, error}), 64'd0);
        chk("midrst_address", 64'(Address), 64'd0);
        chk("midrst_wdata", 64'(Write_data), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_req || busy || done || error || MemRead || MemWrite) idle_bad++;
        end
        chk("midrst_idle", 64'(idle_bad), 64'd0);
        chk("midrst_writes", 64'(wrq.size()), 64'd2);
        chk("midrst_contents", 64'(mem_diff()), 64'd0);

        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Bus initiator for the data-memory port: copies a block of 32-bit words from a source address to a destination address.
- Drives the same Address / Write_data / MemRead / MemWrite / Read_data signals the CPU's MEM stage uses.
- Arbitrates for that port with the CPU through a bus_req/bus_grant handshake.
- Refuses any access to the peripheral region (Address[31:28] == 4'b0100) and reports an error instead.

Parameters:
- LEN_W, 8, width of the word-count field (max block length 2^LEN_W-1 words).
- PERIPH_NIB, 4'b0100, value of Address[31:28] that marks the peripheral region (never accessed).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE
- src_addr  input  32  byte address of first source word; bits [1:0] ignored
- dst_addr  input  32  byte address of first destination word; bits [1:0] ignored
- length  input  LEN_W  number of words to copy
- bus_grant  input  1  CPU has released the memory port to this block
- Read_data  input  32  combinational read data from data memory
- bus_req  output  1  request for the memory port
- Address  output  32  memory address; [1:0] always 2'b00
- Write_data  output  32  memory write data
- MemRead  output  1  read strobe
- MemWrite  output  1  write strobe
- busy  output  1  high from accepted start until done/error
- done  output  1  one-cycle pulse on successful completion
- error  output  1  one-cycle pulse on peripheral-region abort

Behaviour:
- Reset (reset low, any time, asynchronous): state IDLE; all outputs 0; internal src/dst/count/data registers cleared. A reset mid-copy aborts immediately with no further access; words already written stay written.
- States: IDLE, REQ, RD, WR, FIN.
- IDLE:
  - start=1, length!=0: latch src, dst and length (low 2 address bits zeroed), go to REQ, busy=1.
  - start=1, length=0: no bus_req; done pulses the next cycle; busy stays 0.
  - start=0: stay in IDLE.
- REQ: bus_req=1. Move to RD on the first cycle bus_grant=1.
- RD:
  - Check cur_src[31:28]==PERIPH_NIB or cur_dst[31:28]==PERIPH_NIB. If true: no strobe this cycle, go to FIN with error.
  - Otherwise drive MemRead=1 and Address=cur_src; capture Read_data into the data register at the clock edge; go to WR.
- WR: drive MemWrite=1, Address=cur_dst, Write_data=data register. At the edge:
  - cur_src += 4, cur_dst += 4 (modulo 2^32, so the address wraps 0xFFFFFFFC -> 0x00000000); count -= 1.
  - count reaches 0: go to FIN.
  - Else bus_grant=1: go to RD.
  - Else bus_grant=0: go to REQ. The port is yielded between words, never between the RD and WR of one word.
- bus_grant is ignored inside RD and WR; once RD is entered, that word completes.
- FIN: bus_req=0, busy=0; done=1 (or error=1) for exactly one cycle; return to IDLE.
- bus_req stays 1 through REQ, RD and WR; it is 0 in IDLE and FIN.
- Outputs are registered-state driven (Moore); MemRead and MemWrite are never both 1. Address and Write_data are 0 whenever both strobes are 0.
- Throughput: 2 cycles per word with grant held. Total latency from start to done = 1 (REQ) + grant wait + 2*length + 1.
- start while busy is ignored. Inputs src_addr, dst_addr and length may change after the start cycle.
- Overlapping regions copy in ascending order; forward overlap (dst > src within block) propagates earlier words. This is defined behaviour, not an error.

Test Plan:
- Basic copy: preload mem[0x10..0x1C]=A,B,C,D; start with src=0x10, dst=0x80, length=4, grant tied 1 -> mem[0x80..0x8C]=A,B,C,D; done pulse at cycle 10 after start; busy high cycles 1-9; MemRead/MemWrite alternate.
- Grant stall: same copy with bus_grant low for 5 cycles initially and again after word 2 -> bus_req held high while waiting; no strobes while grant is low; final contents identical; done delayed by 5 + stall cycles.
- Zero length: start with length=0 -> done pulse the next cycle; bus_req, busy, MemRead and MemWrite never assert.
- Peripheral abort: src=0x3FFFFFF8, dst=0x100, length=4 -> 2 words copied; third RD sees src=0x40000000, so no strobe, error pulses, done stays 0, mem[0x108] unchanged.
- Wrap-around: src=0xFFFFFFF8, dst=0x200, length=4 -> reads at FFFFFFF8, FFFFFFFC, 00000000, 00000004; done asserted.
- Reset mid-copy: drop reset in the WR of word 2 of a length=8 copy -> all outputs 0 asynchronously; only words 0-1 (and optionally 2) written; after release, engine idles until the next start.
